// File: rtl/sram_arbiter_n.sv
// ---------------------------------------------------------------------------
// sram_arbiter_n
//
// Shares one asynchronous external SRAM among NPORTS bus masters on a single
// clock. Each access walks IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE, so
// one access completes every WAIT_CYCLES+3 cycles and IDLE is always visited
// between accesses. All SRAM pins come straight from flops.
//
// Build option:
//   SRAM_ARB_ROUND_ROBIN_EN  defined   -> round-robin grant, search starts at
//                                         (last grant + 1) mod NPORTS
//                            undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   m_address         per-port word address   (port i: [i*ADDR_W +: ADDR_W])
//   m_wrdata          per-port write data     (port i: [i*DATA_W +: DATA_W])
//   m_byteenable      per-port byte enables   (port i: [i*BE_W +: BE_W])
//   m_rd, m_wr        per-port request; both high is a write
//   m_rddata          per-port registered read data, held until next read
//   m_ack             per-port one-cycle completion pulse
//   ram_address       SRAM address
//   ram_data_o/_i     SRAM write / read data
//   ram_data_oe       drive enable for the SRAM data pins
//   ram_ce_n/oe_n/we_n SRAM strobes, active low
//   ram_be_n          SRAM byte lanes, active low
// ---------------------------------------------------------------------------
module sram_arbiter_n #(
   parameter int  NPORTS      = 2,
   parameter int  ADDR_W      = 20,
   parameter int  DATA_W      = 32,
   parameter int  WAIT_CYCLES = 1,
   localparam int BE_W        = DATA_W / 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NPORTS*ADDR_W-1:0] m_address,
   input  logic [NPORTS*DATA_W-1:0] m_wrdata,
   input  logic [NPORTS*BE_W-1:0]   m_byteenable,
   input  logic [NPORTS-1:0]        m_rd,
   input  logic [NPORTS-1:0]        m_wr,
   output logic [NPORTS*DATA_W-1:0] m_rddata,
   output logic [NPORTS-1:0]        m_ack,
   output logic [ADDR_W-1:0]        ram_address,
   output logic [DATA_W-1:0]        ram_data_o,
   input  logic [DATA_W-1:0]        ram_data_i,
   output logic                     ram_data_oe,
   output logic                     ram_ce_n,
   output logic                     ram_oe_n,
   output logic                     ram_we_n,
   output logic [BE_W-1:0]          ram_be_n
);

   localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE} state_e;

   state_e              state_q;
   logic [IDX_W-1:0]    gnt_q;
   logic                is_wr_q;
   logic [CNT_W-1:0]    wait_cnt_q;
   logic [NPORTS-1:0]   ack_q;
   logic [DATA_W-1:0]   rddata_q [NPORTS];
   logic [ADDR_W-1:0]   ram_address_q;
   logic [DATA_W-1:0]   ram_data_q;
   logic                ram_data_oe_q;
   logic                ram_ce_n_q;
   logic                ram_oe_n_q;
   logic                ram_we_n_q;
   logic [BE_W-1:0]     ram_be_n_q;

   logic [NPORTS-1:0]   req;
   logic [IDX_W-1:0]    gnt_d;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [BE_W-1:0]     sel_be;
   logic                sel_wr;

   assign req = m_rd | m_wr;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] last_q;

   // Rotate the search so the port after the last winner is looked at first.
   always_comb begin : rr_pick
      int                idx;
      logic [NPORTS-1:0] sh;
      logic              found;
      // NOTE: every variable gets a value before any branch, otherwise a
      // path that skips the assignment would infer a latch.
      gnt_d = '0;
      idx   = 0;
      sh    = '0;
      found = 1'b0;
      for (int k = 0; k < NPORTS; k++) begin
         idx = (int'(last_q) + 1 + k) % NPORTS;
         sh  = req >> idx;
         if (!found && sh[0]) begin
            gnt_d = IDX_W'(idx);
            found = 1'b1;
         end
      end
   end
`else
   // Walk from the top down so the lowest requesting index is the last write.
   always_comb begin : fixed_pick
      gnt_d = '0;
      for (int i = NPORTS - 1; i >= 0; i--) begin
         if (req[i]) gnt_d = IDX_W'(i);
      end
   end
`endif

   // Mux the winning port's request fields.
   always_comb begin : grant_mux
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      sel_wr    = 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
         if (gnt_d == IDX_W'(i)) begin
            sel_addr  = m_address[i*ADDR_W +: ADDR_W];
            sel_wdata = m_wrdata[i*DATA_W +: DATA_W];
            sel_be    = m_byteenable[i*BE_W +: BE_W];
            sel_wr    = m_wr[i];
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // register sees the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         gnt_q         <= '0;
         is_wr_q       <= 1'b0;
         wait_cnt_q    <= '0;
         ack_q         <= '0;
         ram_address_q <= '0;
         ram_data_q    <= '0;
         ram_data_oe_q <= 1'b0;
         ram_ce_n_q    <= 1'b1;
         ram_oe_n_q    <= 1'b1;
         ram_we_n_q    <= 1'b1;
         ram_be_n_q    <= '1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         last_q        <= IDX_W'(NPORTS - 1);
`endif
         // NOTE: the read-data holding registers are cleared too, because
         // masters may see m_rddata straight out of reset.
         for (int i = 0; i < NPORTS; i++) rddata_q[i] <= '0;
      end else begin
         ack_q <= '0;
         unique case (state_q)
            ST_IDLE: begin
               if (|req) begin
                  gnt_q         <= gnt_d;
                  is_wr_q       <= sel_wr;
                  ram_address_q <= sel_addr;
                  ram_data_q    <= sel_wdata;
                  // Reads enable every lane; writes use the master's enables.
                  ram_be_n_q    <= sel_wr ? ~sel_be : '0;
                  ram_ce_n_q    <= 1'b0;
                  ram_data_oe_q <= sel_wr;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                  last_q        <= gnt_d;
`endif
                  state_q       <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               ram_oe_n_q <= is_wr_q;
               ram_we_n_q <= ~is_wr_q;
               wait_cnt_q <= CNT_W'(WAIT_CYCLES - 1);
               state_q    <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (wait_cnt_q == '0) begin
                  ram_oe_n_q <= 1'b1;
                  ram_we_n_q <= 1'b1;
                  ram_be_n_q <= '1;
                  for (int i = 0; i < NPORTS; i++) begin
                     if (gnt_q == IDX_W'(i)) begin
                        ack_q[i] <= 1'b1;
                        if (!is_wr_q) rddata_q[i] <= ram_data_i;
                     end
                  end
                  state_q <= ST_DONE;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 1'b1;
               end
            end
            ST_DONE: begin
               // Chip enable and write data were held through DONE for hold time.
               ram_ce_n_q    <= 1'b1;
               ram_data_oe_q <= 1'b0;
               state_q       <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NPORTS; g++) begin : g_rddata
      assign m_rddata[g*DATA_W +: DATA_W] = rddata_q[g];
   end

   assign m_ack       = ack_q;
   assign ram_address = ram_address_q;
   assign ram_data_o  = ram_data_q;
   assign ram_data_oe = ram_data_oe_q;
   assign ram_ce_n    = ram_ce_n_q;
   assign ram_oe_n    = ram_oe_n_q;
   assign ram_we_n    = ram_we_n_q;
   assign ram_be_n    = ram_be_n_q;

endmodule

// File: tb/tb_sram_arbiter_n.sv
// ---------------------------------------------------------------------------
// Bench for sram_arbiter_n. Main instance: NPORTS=2, WAIT_CYCLES=1, with a
// behavioural byte-lane SRAM. Second instance: WAIT_CYCLES=3 whose SRAM read
// data is a fixed function of the address. Acks of the main instance are
// checked by a monitor against a queue of expected responses.
// ---------------------------------------------------------------------------
module tb_sram_arbiter_n;

   localparam int NP = 2;
   localparam int AW = 20;
   localparam int DW = 32;
   localparam int BW = 4;

   typedef struct {
      int          port;
      bit          chk;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Main instance signals
   logic [NP*AW-1:0] m_address    = '0;
   logic [NP*DW-1:0] m_wrdata     = '0;
   logic [NP*BW-1:0] m_byteenable = '0;
   logic [NP-1:0]    m_rd         = '0;
   logic [NP-1:0]    m_wr         = '0;
   logic [NP*DW-1:0] m_rddata;
   logic [NP-1:0]    m_ack;
   logic [AW-1:0]    ram_address;
   logic [DW-1:0]    ram_data_o, ram_data_i;
   logic             ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n;
   logic [BW-1:0]    ram_be_n;

   // WAIT_CYCLES=3 instance signals
   logic [NP*AW-1:0] w3_address    = '0;
   logic [NP*DW-1:0] w3_wrdata     = '0;
   logic [NP*BW-1:0] w3_byteenable = '0;
   logic [NP-1:0]    w3_rd         = '0;
   logic [NP-1:0]    w3_wr         = '0;
   logic [NP*DW-1:0] w3_rddata;
   logic [NP-1:0]    w3_ack;
   logic [AW-1:0]    w3_ram_address;
   logic [DW-1:0]    w3_ram_data_o, w3_ram_data_i;
   logic             w3_ram_data_oe, w3_ram_ce_n, w3_ram_oe_n, w3_ram_we_n;
   logic [BW-1:0]    w3_ram_be_n;

   sram_arbiter_n #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .m_address(m_address), .m_wrdata(m_wrdata), .m_byteenable(m_byteenable),
      .m_rd(m_rd), .m_wr(m_wr), .m_rddata(m_rddata), .m_ack(m_ack),
      .ram_address(ram_address), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
      .ram_data_oe(ram_data_oe), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
      .ram_we_n(ram_we_n), .ram_be_n(ram_be_n)
   );

   sram_arbiter_n #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) dut_w3 (
      .clk(clk), .rst(rst),
      .m_address(w3_address), .m_wrdata(w3_wrdata), .m_byteenable(w3_byteenable),
      .m_rd(w3_rd), .m_wr(w3_wr), .m_rddata(w3_rddata), .m_ack(w3_ack),
      .ram_address(w3_ram_address), .ram_data_o(w3_ram_data_o), .ram_data_i(w3_ram_data_i),
      .ram_data_oe(w3_ram_data_oe), .ram_ce_n(w3_ram_ce_n), .ram_oe_n(w3_ram_oe_n),
      .ram_we_n(w3_ram_we_n), .ram_be_n(w3_ram_be_n)
   );

   // Behavioural SRAM for the main instance: lane writes while we_n is low.
   logic [31:0] mem [0:63];
   assign ram_data_i = !ram_oe_n ? mem[ram_address[5:0]] : 32'h0;
   always @(posedge clk) begin
      if (!ram_ce_n && !ram_we_n && ram_data_oe) begin
         for (int b = 0; b < BW; b++)
            if (!ram_be_n[b]) mem[ram_address[5:0]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
      end
   end

   // Second instance reads back a recognisable pattern of the address.
   assign w3_ram_data_i = !w3_ram_oe_n ? {12'hABC, w3_ram_address} : 32'h0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int we_lo = 0, oe_lo = 0, oe3_lo = 0;
   always @(negedge clk) begin
      if (!ram_we_n)    we_lo  <= we_lo + 1;
      if (!ram_oe_n)    oe_lo  <= oe_lo + 1;
      if (!w3_ram_oe_n) oe3_lo <= oe3_lo + 1;
   end

   int   n_total = 0;
   int   n_pass  = 0;
   exp_t sb_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every ack of the main instance must match the head of the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int p = 0; p < NP; p++) begin
            if (m_ack[p] === 1'b1) begin
               if (sb_q.size() == 0) begin
                  check($sformatf("ack_expected_p%0d", p), sb_q.size(), 1);
               end else begin
                  e = sb_q.pop_front();
                  check("ack_port", p, e.port);
                  check("ack_cycle", cyc, e.cyc);
                  if (e.chk) check("rddata", m_rddata[p*DW +: DW], e.data);
               end
            end
         end
      end
   end

   task automatic issue(input int port, input bit rd, input bit wr,
                        input logic [19:0] a, input logic [31:0] d, input logic [3:0] be);
      m_address[port*AW +: AW]   = a;
      m_wrdata[port*DW +: DW]    = d;
      m_byteenable[port*BW +: BW] = be;
      m_rd[port] = rd;
      m_wr[port] = wr;
   endtask

   task automatic wait_ack(input int port);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (m_ack[port] === 1'b1) seen = 1'b1;
      end
      check($sformatf("ack_seen_p%0d", port), seen, 1);
   endtask

   // One complete access by a master; ack expected WAIT_CYCLES+2 after issue.
   task automatic access(input int port, input bit rd, input bit wr,
                         input logic [19:0] a, input logic [31:0] d, input logic [3:0] be,
                         input bit chk, input logic [31:0] exp_d);
      exp_t e;
      @(posedge clk); #1;
      issue(port, rd, wr, a, d, be);
      e.port = port; e.chk = chk; e.data = exp_d; e.cyc = cyc + 3;
      sb_q.push_back(e);
      wait_ack(port);
      @(posedge clk); #1;
      m_rd[port] = 1'b0;
      m_wr[port] = 1'b0;
   endtask

   task automatic w3_read(input int port, input logic [19:0] a, input logic [31:0] exp_d);
      int p, o;
      bit seen = 1'b0;
      @(posedge clk); #1;
      w3_address[port*AW +: AW] = a;
      w3_rd[port] = 1'b1;
      p = cyc;
      o = oe3_lo;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (w3_ack[port] === 1'b1) seen = 1'b1;
      end
      check("w3_ack_seen", seen, 1);
      check("w3_ack_cycle", cyc, p + 5);
      check("w3_rddata", w3_rddata[port*DW +: DW], exp_d);
      check("w3_oe_low_cycles", oe3_lo - o, 3);
      @(posedge clk); #1;
      w3_rd[port] = 1'b0;
   endtask

   initial begin
      int   w0, o0, p;
      bit   seen;
      exp_t e;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b111);
      check("rst_be_n", ram_be_n, 4'hF);
      check("rst_data_oe", ram_data_oe, 0);
      check("rst_addr_data", {ram_address, ram_data_o}, 0);
      check("rst_ack", m_ack, 0);
      check("rst_rddata", m_rddata, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Full-word write then read back on port 0
      w0 = we_lo;
      access(0, 0, 1, 20'h00010, 32'hDEADBEEF, 4'hF, 0, 0);
      check("we_low_cycles", we_lo - w0, 1);
      o0 = oe_lo;
      access(0, 1, 0, 20'h00010, 32'h0, 4'h0, 1, 32'hDEADBEEF);
      check("oe_low_cycles", oe_lo - o0, 1);

      // Byte-lane write and an all-zero-enable write
      access(1, 0, 1, 20'h00011, 32'h11223344, 4'hF,    0, 0);
      access(1, 0, 1, 20'h00011, 32'h00AA0000, 4'b0100, 0, 0);
      access(1, 1, 0, 20'h00011, 32'h0,        4'h0,    1, 32'h11AA3344);
      access(0, 0, 1, 20'h00011, 32'hFFFFFFFF, 4'b0000, 0, 0);
      access(0, 1, 0, 20'h00011, 32'h0,        4'h0,    1, 32'h11AA3344);

      // Read and write both high is a write
      access(1, 1, 1, 20'h00020, 32'hCAFEF00D, 4'hF, 0, 0);
      access(1, 1, 0, 20'h00020, 32'h0,        4'h0, 1, 32'hCAFEF00D);

      // Reset in the middle of a write
      @(posedge clk); #1;
      issue(0, 0, 1, 20'h00030, 32'h5555AAAA, 4'hF);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (ram_we_n === 1'b0) seen = 1'b1;
      end
      check("rst_mid_reached_access", seen, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b111);
      check("rst_mid_data_oe", ram_data_oe, 0);
      check("rst_mid_be_n", ram_be_n, 4'hF);
      check("rst_mid_ack", m_ack, 0);
      check("rst_mid_rddata0", m_rddata[0 +: DW], 0);
      m_rd = '0;
      m_wr = '0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Both ports request continuously (be=0 writes leave memory intact)
      @(posedge clk); #1;
      issue(0, 0, 1, 20'h0003E, 32'h0, 4'h0);
      issue(1, 0, 1, 20'h0003F, 32'h0, 4'h0);
      p = cyc;
      for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         e.port = k % 2;
`else
         e.port = 0;
`endif
         e.chk = 1'b0; e.data = 32'h0; e.cyc = p + 3 + 4 * k;
         sb_q.push_back(e);
      end
      repeat (15) @(posedge clk);
      #1;
      m_wr = '0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("contention_drained", sb_q.size(), 0);

      // FSM came back to IDLE after reset: normal latency and data
      access(0, 1, 0, 20'h00010, 32'h0, 4'h0, 1, 32'hDEADBEEF);

      // WAIT_CYCLES=3 instance: reads on both ports, slices independent
      w3_read(1, 20'h00055, 32'hABC00055);
      w3_read(0, 20'h00077, 32'hABC00077);
      check("w3_other_port_held", w3_rddata[1*DW +: DW], 32'hABC00055);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sram_arbiter_n.md
# sram_arbiter_n

Parametrised N-port arbiter that shares a single asynchronous external SRAM among several bus masters (instruction bus, data bus, DMA, etc.) on one clock. Next generation of the dual-port main-RAM front end: no 2x clock, arbitrary port count, programmable SRAM wait states, and a per-port ack handshake instead of fixed-slot time multiplexing. Sits between the ibus/dbus RAM slave ports and the board SRAM pins; the SoC top level builds the tri-state data bus from `ram_data_o`/`ram_data_oe`.

## Interface
- `NPORTS`, 2: number of master ports, legal range 1..8.
- `ADDR_W`, 20: word address width.
- `DATA_W`, 32: data width, multiple of 8; `BE_W = DATA_W/8`.
- `WAIT_CYCLES`, 1: SRAM strobe cycles per access, legal range 1..15.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m_address`  in  NPORTS*ADDR_W  per-port word address; port i in slice [i*ADDR_W +: ADDR_W].
- `m_wrdata`  in  NPORTS*DATA_W  per-port write data.
- `m_byteenable`  in  NPORTS*BE_W  per-port byte enables (write only).
- `m_rd`  in  NPORTS  per-port read request.
- `m_wr`  in  NPORTS  per-port write request.
- `m_rddata`  out  NPORTS*DATA_W  per-port registered read data.
- `m_ack`  out  NPORTS  one-cycle completion pulse per port.
- `ram_address`  out  ADDR_W  SRAM address.
- `ram_data_o`  out  DATA_W  SRAM write data.
- `ram_data_i`  in  DATA_W  SRAM read data.
- `ram_data_oe`  out  1  drive enable for the data pins.
- `ram_ce_n`, `ram_oe_n`, `ram_we_n`  out  1 each  SRAM strobes, active low.
- `ram_be_n`  out  BE_W  SRAM byte lanes, active low.

## Operation
- Port i requests when `m_rd[i] | m_wr[i]`; both high is treated as a write. Master holds address/data/request stable until it sees `m_ack[i]`, then must drop or change the request the following cycle.
- FSM: IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles, down-counter) -> DONE -> IDLE.
- IDLE: if any request, latch grant index, address, wrdata, byteenable, direction; go SETUP. Otherwise stay.
- SETUP: `ram_ce_n`=0, address/`ram_be_n` driven; write: `ram_data_oe`=1.
- ACCESS: read: `ram_oe_n`=0, `ram_be_n`=0 all lanes; write: `ram_we_n`=0, `ram_be_n`=~byteenable. Read data captured from `ram_data_i` into `m_rddata[grant]` on the edge ending the last ACCESS cycle.
- DONE: strobes deasserted except `ram_ce_n`=0; write keeps `ram_data_oe`=1 (hold time); `m_ack[grant]`=1.
- Write with byteenable all zero still runs a full cycle and acks; no lane written.
- `m_rddata` slices hold value until the next read to the same port; untouched by writes or other ports.
- Arbitration per Configuration; pointer updates only on grant.

## Timing
- Reset values: FSM IDLE, `m_ack`=0, `m_rddata`=0, `ram_ce_n`=`ram_oe_n`=`ram_we_n`=1, `ram_be_n` all 1, `ram_data_oe`=0, `ram_address`=0, `ram_data_o`=0, RR pointer=NPORTS-1.
- All SRAM outputs registered; no glitches.
- Latency: request sampled in cycle t -> `m_ack` in cycle t+WAIT_CYCLES+2 (WAIT_CYCLES=1: 3 cycles after sample, ack in 4th cycle counting t).
- Throughput: one access per WAIT_CYCLES+3 cycles; IDLE always visited between accesses.
- Request arriving in DONE for another port waits for next IDLE; acked port's stale request in DONE is not re-sampled.
- Reset mid-access: next cycle all outputs at reset values, no ack issued, access dropped.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN` defined: round-robin; search starts at (last grant+1) mod NPORTS.
- Undefined: fixed priority, lowest index wins; pointer logic not compiled.

## Test plan
- NPORTS=2, WAIT_CYCLES=1: port 0 writes 0xDEADBEEF to 0x00010, be=4'b1111 -> `ram_we_n` low exactly 1 cycle, ack 4th cycle; read back -> `m_rddata[0]`=0xDEADBEEF.
- Byte write be=4'b0100 data 0x00AA0000 over 0x11223344 -> read returns 0x11AA3344; be=0 write leaves word unchanged, still acks.
- Ports 0 and 1 request continuously: RR build -> grants 0,1,0,1; fixed build -> port 1 starves while port 0 stays asserted.
- WAIT_CYCLES=3: read -> `ram_oe_n` low 3 cycles, ack at t+5; other port's `m_rddata` unchanged.
- Assert `rst` during ACCESS of a write -> next cycle all strobes high, `ram_data_oe`=0, no ack; FSM resumes from IDLE.
- `m_rd` and `m_wr` both high -> write cycle performed.
